// File: rtl/vload_pkg.sv
// Shared types and helpers for the vector operand loader.
package vload_pkg;

  // Loader sequencing: fill a, fill b, then present the pair.
  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } vload_state_t;

  // Width of the element index counter; never narrower than one bit.
  function automatic int idx_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/vector_operand_loader_if.sv
// Element stream in, operand pair out. The slave side is the loader,
// the master side is whatever feeds the stream and consumes the pair.
interface vector_operand_loader_if #(
  parameter int WIDTH = 32,
  parameter int LEN   = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_a [LEN-1:0];
  logic [WIDTH-1:0] out_b [LEN-1:0];

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_a, out_b
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_a, out_b
  );

endinterface

// File: rtl/vector_operand_reg.sv
// LEN x WIDTH register bank: one indexed write port, synchronous
// whole-bank clear, asynchronous reset to zero.
module vector_operand_reg
  import vload_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LEN   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      we,
  input  logic [idx_width(LEN)-1:0] idx,
  input  logic [WIDTH-1:0]          data,
  output logic [WIDTH-1:0]          q [LEN-1:0]
);

  // Element storage: reset/clear zero the whole bank, otherwise write one slot.
  // NOTE: every element is reset because a discarded partial load must read
  // back as zero; this bank is flops, not a RAM, so the reset is cheap to map.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LEN; i++) q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < LEN; i++) q[i] <= '0;
    end else if (we) begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      q[idx] <= data;
    end
  end

endmodule

// File: rtl/vector_operand_loader.sv
// Assembles operand vectors a then b from a serial element stream and
// presents them in parallel to the vector adder.
// Optional feature: define VLOAD_EARLY_LAST_EN to let in_last end a vector
// early; otherwise in_last is ignored and every vector is LEN elements.
module vector_operand_loader
  import vload_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LEN   = 8
) (
  input logic                   clk,
  input logic                   rst,
  vector_operand_loader_if.slave bus
);

  localparam int IW = idx_width(LEN);
  typedef logic [IW-1:0] idx_t;

  vload_state_t     state, state_n;
  idx_t             idx, idx_n;
  logic             accept;
  logic             last_hit;
  logic             end_vec;
  logic             we_a, we_b, clr;
  logic [WIDTH-1:0] a_q [LEN-1:0];
  logic [WIDTH-1:0] b_q [LEN-1:0];

`ifdef VLOAD_EARLY_LAST_EN
  assign last_hit = bus.in_last;
`else
  logic unused_last;
  assign unused_last = bus.in_last;
  assign last_hit    = 1'b0;
`endif

  // Handshake decode: ready/valid depend on state only.
  assign bus.in_ready  = (state != HOLD);
  assign bus.out_valid = (state == HOLD);
  assign accept        = bus.in_valid & bus.in_ready;
  assign end_vec       = (idx == idx_t'(LEN - 1)) | last_hit;

  // State and index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD_A;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // Next-state, index advance and bank write/clear strobes.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    state_n = state;
    idx_n   = idx;
    we_a    = 1'b0;
    we_b    = 1'b0;
    clr     = 1'b0;
    unique case (state)
      LOAD_A: begin
        if (accept) begin
          we_a = 1'b1;
          if (end_vec) begin
            idx_n   = '0;
            state_n = LOAD_B;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      LOAD_B: begin
        if (accept) begin
          we_b = 1'b1;
          if (end_vec) begin
            idx_n   = '0;
            state_n = HOLD;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      HOLD: begin
        // Pair consumed: wipe both banks so a short next load reads zeros.
        if (bus.out_ready) begin
          clr     = 1'b1;
          state_n = LOAD_A;
        end
      end
      default: begin
        state_n = LOAD_A;
        idx_n   = '0;
      end
    endcase
  end

  vector_operand_reg #(.WIDTH(WIDTH), .LEN(LEN)) u_reg_a (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .we   (we_a),
    .idx  (idx),
    .data (bus.in_data),
    .q    (a_q)
  );

  vector_operand_reg #(.WIDTH(WIDTH), .LEN(LEN)) u_reg_b (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .we   (we_b),
    .idx  (idx),
    .data (bus.in_data),
    .q    (b_q)
  );

  assign bus.out_a = a_q;
  assign bus.out_b = b_q;

endmodule

// File: tb/tb_vector_operand_loader.sv
// Directed bench for vector_operand_loader (WIDTH=8, LEN=4, plus a LEN=2
// instance). Works with or without VLOAD_EARLY_LAST_EN defined.
module tb_vector_operand_loader;

  localparam int W  = 8;
  localparam int L  = 4;
  localparam int L2 = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vector_operand_loader_if #(.WIDTH(W), .LEN(L))  bus  ();
  vector_operand_loader_if #(.WIDTH(W), .LEN(L2)) bus2 ();

  vector_operand_loader #(.WIDTH(W), .LEN(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  vector_operand_loader #(.WIDTH(W), .LEN(L2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [7:0]  s [8];
    bit          gaps;
    int          hold;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  vec_t tbl [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_a();
    return {bus.out_a[3], bus.out_a[2], bus.out_a[1], bus.out_a[0]};
  endfunction

  function automatic logic [31:0] pack_b();
    return {bus.out_b[3], bus.out_b[2], bus.out_b[1], bus.out_b[0]};
  endfunction

  function automatic logic [31:0] pack2_a();
    return {16'h0, bus2.out_a[1], bus2.out_a[0]};
  endfunction

  function automatic logic [31:0] pack2_b();
    return {16'h0, bus2.out_b[1], bus2.out_b[0]};
  endfunction

  // Advance to just after the next rising edge (drive phase).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      bus.in_data = 8'($urandom);
      tick();
    end
  endtask

  // Offer one element until accepted, bounded.
  task automatic send(input logic [7:0] d, input logic last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 for data %0h", d);
    end
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  // Check a presented pair, hold it, then consume and check the clear.
  task automatic finish_pair(input string name, input int hold,
                             input logic [31:0] ea, input logic [31:0] eb);
    @(negedge clk);
    check({name, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    check({name, "_in_ready"},  32'(bus.in_ready),  32'd0);
    check({name, "_a"}, pack_a(), ea);
    check({name, "_b"}, pack_b(), eb);
    for (int h = 0; h < hold; h++) begin
      tick();
      @(negedge clk);
      check({name, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({name, "_hold_ready"}, 32'(bus.in_ready),  32'd0);
      check({name, "_hold_a"}, pack_a(), ea);
      check({name, "_hold_b"}, pack_b(), eb);
    end
    bus.out_ready = 1'b1;
    tick();
    @(negedge clk);
    check({name, "_after_valid"}, 32'(bus.out_valid), 32'd0);
    check({name, "_after_ready"}, 32'(bus.in_ready),  32'd1);
    check({name, "_clr_a"}, pack_a(), 32'h0);
    check({name, "_clr_b"}, pack_b(), 32'h0);
    bus.out_ready = 1'b0;
    tick();
  endtask

  initial begin
    // Vector table.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) tbl[r].s[i] = 8'(i + 1);
      tbl[r].ea = 32'h04030201;
      tbl[r].eb = 32'h08070605;
    end
    tbl[0].name = "stream";  tbl[0].gaps = 1'b0; tbl[0].hold = 0;
    tbl[1].name = "hold5";   tbl[1].gaps = 1'b0; tbl[1].hold = 5;
    tbl[2].name = "gaps";    tbl[2].gaps = 1'b1; tbl[2].hold = 0;
    tbl[3].name = "extreme"; tbl[3].gaps = 1'b0; tbl[3].hold = 1;
    tbl[3].s[0] = 8'hFF; tbl[3].s[1] = 8'h00; tbl[3].s[2] = 8'h80; tbl[3].s[3] = 8'h7F;
    tbl[3].s[4] = 8'h01; tbl[3].s[5] = 8'hFE; tbl[3].s[6] = 8'h55; tbl[3].s[7] = 8'hAA;
    tbl[3].ea = 32'h7F8000FF;
    tbl[3].eb = 32'hAA55FE01;

    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.in_data   = '0;
    bus2.in_last   = 1'b0;
    bus2.out_ready = 1'b0;

    // Reset state.
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_a", pack_a(), 32'h0);
    check("rst_b", pack_b(), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Table-driven pairs.
    for (int r = 0; r < 4; r++) begin
      bus.out_ready = (tbl[r].hold == 0);
      for (int i = 0; i < 8; i++) begin
        if (tbl[r].gaps) idle(int'($urandom_range(0, 2)));
        send(tbl[r].s[i], 1'b0);
        if (i == 6) begin
          @(negedge clk);
          check({tbl[r].name, "_early_valid"}, 32'(bus.out_valid), 32'd0);
          tick();
        end
      end
      finish_pair(tbl[r].name, tbl[r].hold, tbl[r].ea, tbl[r].eb);
    end

    // Reset mid-load after 6 elements, then a fresh pair.
    for (int i = 1; i <= 6; i++) send(8'(i), 1'b0);
    rst = 1'b1;
    #2;
    check("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_a", pack_a(), 32'h0);
    check("mid_rst_b", pack_b(), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    for (int i = 9; i <= 16; i++) send(8'(i), 1'b0);
    finish_pair("after_rst", 0, 32'h0C0B0A09, 32'h100F0E0D);

    // in_last handling: 1, 2(last), 5, 6, 7, 8.
    send(8'd1, 1'b0);
    send(8'd2, 1'b1);
    send(8'd5, 1'b0);
    send(8'd6, 1'b0);
    send(8'd7, 1'b0);
    send(8'd8, 1'b0);
`ifdef VLOAD_EARLY_LAST_EN
    finish_pair("early_last", 1, 32'h00000201, 32'h08070605);
`else
    @(negedge clk);
    check("nolast_out_valid", 32'(bus.out_valid), 32'd0);
    check("nolast_in_ready",  32'(bus.in_ready),  32'd1);
    check("nolast_a", pack_a(), 32'h06050201);
    tick();
    send(8'd9, 1'b0);
    send(8'd10, 1'b0);
    finish_pair("nolast", 1, 32'h06050201, 32'h0A090807);
`endif

    // LEN=2 back-to-back pairs: three pairs from 12 elements.
    begin
      int  cnt   = 0;
      int  pairs = 0;
      logic acc;
      bus2.out_ready = 1'b1;
      bus2.in_valid  = 1'b1;
      bus2.in_data   = 8'd1;
      for (int cyc = 0; cyc < 20; cyc++) begin
        @(negedge clk);
        acc = bus2.in_valid & bus2.in_ready;
        if (bus2.out_valid) begin
          check("len2_a", pack2_a(), {16'h0, 8'(4 * pairs + 2), 8'(4 * pairs + 1)});
          check("len2_b", pack2_b(), {16'h0, 8'(4 * pairs + 4), 8'(4 * pairs + 3)});
          check("len2_hold_ready", 32'(bus2.in_ready), 32'd0);
          pairs++;
        end else if (bus2.in_valid) begin
          check("len2_load_ready", 32'(bus2.in_ready), 32'd1);
        end
        tick();
        if (acc) begin
          cnt++;
          bus2.in_data = 8'(cnt + 1);
          if (cnt == 12) bus2.in_valid = 1'b0;
        end
      end
      check("len2_pairs", 32'(pairs), 32'd3);
      check("len2_elems", 32'(cnt), 32'd12);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
